// File: rtl/writeback_unit.sv
// Writeback stage: retires instructions into both regfile write ports,
// supplies the decode bypass network and counts retired instructions.
module writeback_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             in_wb_en,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_result,
  input  logic             in_is_load,
  input  logic [1:0]       in_load_size,
  input  logic [1:0]       in_byte_off,
  input  logic             in_sign_ext,
  input  logic             in_inc_en,
  input  logic [4:0]       in_inc_rd,
  input  logic [31:0]      in_inc_val,
  input  logic [31:0]      mem_rdata,
  output logic             wen0,
  output logic [4:0]       waddr0,
  output logic [31:0]      wdata0,
  output logic             wen1,
  output logic [4:0]       waddr1,
  output logic [31:0]      wdata1,
  input  logic [4:0]       fwd_raddr0,
  input  logic [4:0]       fwd_raddr1,
  output logic             fwd_hit0,
  output logic             fwd_hit1,
  output logic [31:0]      fwd_data0,
  output logic [31:0]      fwd_data1,
  output logic [CNT_W-1:0] retired
);

  logic        v, first;
  logic        wb_en, is_load, sign_ext, inc_en;
  logic [4:0]  rd, inc_rd;
  logic [31:0] result, inc_val, hold_data;
  logic [1:0]  load_size, byte_off;

  logic        h0_v, h1_v;
  logic [4:0]  h0_a, h1_a;
  logic [31:0] h0_d, h1_d;

  logic        commit;
  logic [31:0] ld_raw, ld_ext;
  logic [15:0] half;
  logic [7:0]  byte_v;

  assign commit = v & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      v       <= 1'b0;
      first   <= 1'b0;
      h0_v    <= 1'b0;
      h0_a    <= '0;
      h0_d    <= '0;
      h1_v    <= 1'b0;
      h1_a    <= '0;
      h1_d    <= '0;
      retired <= '0;
    end else begin
      if (!stall) begin
        v     <= in_valid;
        first <= in_valid;
      end else begin
        first <= 1'b0;
      end
      h0_v <= wen0;
      h0_a <= waddr0;
      h0_d <= wdata0;
      h1_v <= wen1;
      h1_a <= waddr1;
      h1_d <= wdata1;
      if (commit)
        retired <= retired + 1'b1;
    end
  end

  // Payload fields need no reset; they are qualified by v.
  always_ff @(posedge clk) begin
    if (!stall) begin
      wb_en     <= in_wb_en;
      rd        <= in_rd;
      result    <= in_result;
      is_load   <= in_is_load;
      load_size <= in_load_size;
      byte_off  <= in_byte_off;
      sign_ext  <= in_sign_ext;
      inc_en    <= in_inc_en;
      inc_rd    <= in_inc_rd;
      inc_val   <= in_inc_val;
    end
    // mem_rdata is only valid in the first cycle; keep it across stalls.
    if (first && is_load)
      hold_data <= mem_rdata;
  end

  always_comb begin
    ld_raw = first ? mem_rdata : hold_data;
    half   = byte_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (byte_off)
      2'd0:    byte_v = ld_raw[7:0];
      2'd1:    byte_v = ld_raw[15:8];
      2'd2:    byte_v = ld_raw[23:16];
      default: byte_v = ld_raw[31:24];
    endcase
    case (load_size)
      2'd1:    ld_ext = {{16{sign_ext & half[15]}}, half};
      2'd2:    ld_ext = {{24{sign_ext & byte_v[7]}}, byte_v};
      default: ld_ext = ld_raw;
    endcase
  end

  always_comb begin
    wen0   = commit & wb_en & (rd != 5'd0);
    waddr0 = v ? rd : 5'd0;
    wdata0 = v ? (is_load ? ld_ext : result) : 32'd0;
    wen1   = commit & inc_en & (inc_rd != 5'd0)
           & ~(wen0 & (inc_rd == rd));
    waddr1 = v ? inc_rd : 5'd0;
    wdata1 = v ? inc_val : 32'd0;
  end

  logic [4:0]  ra  [2];
  logic        hit [2];
  logic [31:0] dat [2];

  assign ra[0] = fwd_raddr0;
  assign ra[1] = fwd_raddr1;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      hit[k] = 1'b0;
      dat[k] = 32'd0;
      if (ra[k] != 5'd0) begin
        case (1'b1)
          (wen0 && waddr0 == ra[k]): begin hit[k] = 1'b1; dat[k] = wdata0; end
          (wen1 && waddr1 == ra[k]): begin hit[k] = 1'b1; dat[k] = wdata1; end
          (h0_v && h0_a == ra[k]):   begin hit[k] = 1'b1; dat[k] = h0_d;   end
          (h1_v && h1_a == ra[k]):   begin hit[k] = 1'b1; dat[k] = h1_d;   end
          default: ;
        endcase
      end
    end
  end

  assign fwd_hit0  = hit[0];
  assign fwd_data0 = dat[0];
  assign fwd_hit1  = hit[1];
  assign fwd_data1 = dat[1];

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: commits, load extraction, stalls,
// dual-port conflicts, bypass priority and reset behaviour.
module tb_writeback_unit;

  logic        clk, rst, stall;
  logic        in_valid, in_wb_en, in_is_load, in_sign_ext, in_inc_en;
  logic [4:0]  in_rd, in_inc_rd;
  logic [31:0] in_result, in_inc_val, mem_rdata;
  logic [1:0]  in_load_size, in_byte_off;
  logic        wen0, wen1, fwd_hit0, fwd_hit1;
  logic [4:0]  waddr0, waddr1, fwd_raddr0, fwd_raddr1;
  logic [31:0] wdata0, wdata1, fwd_data0, fwd_data1;
  logic [31:0] retired;

  int nvec = 0;
  int nerr = 0;

  writeback_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .in_valid(in_valid), .in_wb_en(in_wb_en), .in_rd(in_rd),
    .in_result(in_result), .in_is_load(in_is_load),
    .in_load_size(in_load_size), .in_byte_off(in_byte_off),
    .in_sign_ext(in_sign_ext), .in_inc_en(in_inc_en),
    .in_inc_rd(in_inc_rd), .in_inc_val(in_inc_val),
    .mem_rdata(mem_rdata),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .fwd_raddr0(fwd_raddr0), .fwd_raddr1(fwd_raddr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; in_wb_en = 0; in_rd = 0; in_result = 0;
    in_is_load = 0; in_load_size = 0; in_byte_off = 0;
    in_sign_ext = 0; in_inc_en = 0; in_inc_rd = 0; in_inc_val = 0;
  endtask

  task automatic instr(input logic [4:0] rd, input logic [31:0] res,
                       input logic ld, input logic [1:0] sz,
                       input logic [1:0] off, input logic sx);
    idle();
    in_valid = 1; in_wb_en = 1; in_rd = rd; in_result = res;
    in_is_load = ld; in_load_size = sz; in_byte_off = off;
    in_sign_ext = sx;
  endtask

  initial begin
    clk = 0; rst = 1; stall = 0; mem_rdata = 0;
    fwd_raddr0 = 0; fwd_raddr1 = 0;
    idle();
    tick(); tick();
    rst = 0; #1;
    chk("rst_wen0", wen0, 0);
    chk("rst_wen1", wen1, 0);
    chk("rst_waddr0", waddr0, 0);
    chk("rst_wdata0", wdata0, 0);
    chk("rst_retired", retired, 0);
    chk("rst_hit0", fwd_hit0, 0);

    // simple ALU commit
    instr(5, 32'h1234, 0, 0, 0, 0);
    tick(); idle(); #1;
    chk("alu_wen0", wen0, 1);
    chk("alu_waddr0", waddr0, 5);
    chk("alu_wdata0", wdata0, 32'h1234);
    chk("alu_wen1", wen1, 0);
    chk("alu_ret0", retired, 0);
    tick();
    chk("alu_wen0_off", wen0, 0);
    chk("alu_ret1", retired, 1);

    // byte / half / reserved-size loads back to back
    instr(3, 0, 1, 2'd2, 2'd2, 1);
    tick();
    instr(6, 0, 1, 2'd1, 2'd2, 0);
    mem_rdata = 32'h0080FF00; #1;
    chk("lb_wen0", wen0, 1);
    chk("lb_waddr0", waddr0, 3);
    chk("lb_wdata0", wdata0, 32'hFFFFFF80);
    tick();
    instr(10, 0, 1, 2'd3, 2'd2, 1); #1;
    chk("lhu_waddr0", waddr0, 6);
    chk("lhu_wdata0", wdata0, 32'h00000080);
    tick();
    mem_rdata = 32'hCAFEF00D; idle(); #1;
    chk("lres_wdata0", wdata0, 32'hCAFEF00D);
    tick();
    chk("ld_ret", retired, 4);

    // load stalled three cycles while mem_rdata changes
    instr(8, 0, 1, 2'd2, 2'd1, 0);
    tick();
    stall = 1; idle(); mem_rdata = 32'h00005A00; #1;
    chk("stall_wen0_a", wen0, 0);
    tick();
    mem_rdata = 32'hDEADBEEF; #1;
    chk("stall_wen0_b", wen0, 0);
    tick();
    chk("stall_wen0_c", wen0, 0);
    chk("stall_ret", retired, 4);
    tick();
    stall = 0; #1;
    chk("rel_wen0", wen0, 1);
    chk("rel_wdata0", wdata0, 32'h0000005A);
    tick();
    chk("rel_ret", retired, 5);
    chk("rel_wen0_off", wen0, 0);

    // post-increment load, then same-register conflict
    instr(7, 0, 1, 2'd0, 2'd0, 0);
    in_inc_en = 1; in_inc_rd = 9; in_inc_val = 32'h100;
    tick();
    mem_rdata = 32'h11223344; in_inc_rd = 7; #1;
    chk("pi_wen0", wen0, 1);
    chk("pi_wdata0", wdata0, 32'h11223344);
    chk("pi_wen1", wen1, 1);
    chk("pi_waddr1", waddr1, 9);
    chk("pi_wdata1", wdata1, 32'h100);
    tick();
    idle(); fwd_raddr1 = 9; #1;
    chk("cf_wen0", wen0, 1);
    chk("cf_wdata0", wdata0, 32'h11223344);
    chk("cf_wen1", wen1, 0);
    chk("h1_hit1", fwd_hit1, 1);
    chk("h1_data1", fwd_data1, 32'h100);
    tick();
    fwd_raddr1 = 0; #1;
    chk("pi_ret", retired, 7);

    // bypass: current write, then history
    instr(4, 32'hAA, 0, 0, 0, 0); fwd_raddr0 = 4;
    tick(); idle(); #1;
    chk("cur_hit0", fwd_hit0, 1);
    chk("cur_data0", fwd_data0, 32'hAA);
    tick();
    chk("h0_wen0", wen0, 0);
    chk("h0_hit0", fwd_hit0, 1);
    chk("h0_data0", fwd_data0, 32'hAA);

    // current write beats older history entry
    instr(4, 32'hAA, 0, 0, 0, 0);
    tick();
    instr(4, 32'hBB, 0, 0, 0, 0);
    tick(); idle(); #1;
    chk("pri_hit0", fwd_hit0, 1);
    chk("pri_data0", fwd_data0, 32'hBB);
    tick();
    chk("pri_h0_data0", fwd_data0, 32'hBB);
    chk("fwd_ret", retired, 10);

    // rd=0 never writes nor hits
    fwd_raddr0 = 0;
    instr(0, 32'h55, 0, 0, 0, 0);
    tick(); idle(); #1;
    chk("r0_wen0", wen0, 0);
    chk("r0_hit0", fwd_hit0, 0);
    chk("r0_data0", fwd_data0, 0);
    tick();
    chk("r0_ret", retired, 11);

    // reset with an instruction in stage
    instr(12, 32'h77, 0, 0, 0, 0);
    fwd_raddr0 = 12; fwd_raddr1 = 12;
    tick();
    idle(); rst = 1; #1;
    chk("pre_rst_wen0", wen0, 1);
    tick();
    rst = 0; #1;
    chk("post_rst_wen0", wen0, 0);
    chk("post_rst_waddr0", waddr0, 0);
    chk("post_rst_ret", retired, 0);
    chk("post_rst_hit0", fwd_hit0, 0);
    chk("post_rst_hit1", fwd_hit1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
